piso_tx: RTL

- Parallel-in, serial-out transmitter; the transmit end of the serial bit link whose receive end is the team's `sipo` block.
- Accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per clock.
- Drives a frame-start and a last-bit marker with the bit stream.
- Supports back-to-back frames with no idle gap.

---
 rtl/piso_pkg.sv | 15 +
 rtl/piso_tx.sv | 109 ++++++++++
 2 files changed

// File: rtl/piso_pkg.sv
// Shared state encoding and frame sizing helpers for the piso_tx serializer.
package piso_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

    function automatic int frame_len(input int width, input bit parity);
        return parity ? width + 1 : width;
    endfunction

endpackage

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with frame-start and last-bit markers.
// Define PISO_TX_PARITY_EN to append an even-parity bit to every frame.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             out_first,
    output logic             out_last
);

`ifdef PISO_TX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam int FRAME_LEN = frame_len(WIDTH, PARITY_EN);
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT     = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] PRE_LAST_CNT = CNT_W'(FRAME_LEN - 2);

    piso_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FRAME_LEN-1:0] shreg_q, shreg_d;
    logic [FRAME_LEN-1:0] frame;
    logic                 out_bit_q, out_bit_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_first_q, out_first_d;
    logic                 out_last_q, out_last_d;
    logic                 accept;

    assign load_ready = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == LAST_CNT));
    assign accept     = load_valid && load_ready;

    // Frame laid out in transmit order: frame[0] goes on the wire first.
    always_comb begin
        frame = '0;
        for (int i = 0; i < WIDTH; i++) begin
            frame[i] = (MSB_FIRST != 0) ? load_data[WIDTH-1-i] : load_data[i];
        end
`ifdef PISO_TX_PARITY_EN
        frame[WIDTH] = ^load_data;
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        out_bit_d   = 1'b0;
        out_valid_d = 1'b0;
        out_first_d = 1'b0;
        out_last_d  = 1'b0;

        if (accept) begin
            state_d     = SHIFT;
            cnt_d       = '0;
            shreg_d     = frame >> 1;
            out_bit_d   = frame[0];
            out_valid_d = 1'b1;
            out_first_d = 1'b1;
        end else if ((state_q == SHIFT) && (cnt_q != LAST_CNT)) begin
            cnt_d       = cnt_q + 1'b1;
            shreg_d     = shreg_q >> 1;
            out_bit_d   = shreg_q[0];
            out_valid_d = 1'b1;
            out_last_d  = (cnt_q == PRE_LAST_CNT);
        end else if (state_q == SHIFT) begin
            state_d = IDLE;
            cnt_d   = '0;
            shreg_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_bit   = out_bit_q;
    assign out_valid = out_valid_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;

endmodule
